// File: rtl/led_sw_avalon_ctrl.sv
// led_sw_avalon_ctrl: Avalon-MM slave driving PWM-dimmed LEDs and reading debounced, edge-captured switches
module led_sw_avalon_ctrl #(
    parameter int NUM_LEDS        = 8,
    parameter int NUM_SW          = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PWM_PRESCALE    = 195
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    output logic [31:0]         avs_readdata,
    output logic                irq,
    input  logic [NUM_SW-1:0]   sw_in,
    output logic [NUM_LEDS-1:0] led_out
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = $clog2(PWM_PRESCALE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(PWM_PRESCALE - 1);

    logic [7:0]          shadow_q [NUM_LEDS];
    logic [7:0]          shadow_d [NUM_LEDS];
    logic [7:0]          active_q [NUM_LEDS];
    logic [7:0]          active_d [NUM_LEDS];
    logic [CW-1:0]       cnt_q    [NUM_SW];
    logic [CW-1:0]       cnt_d    [NUM_SW];
    logic [NUM_SW-1:0]   sync1_q, sync1_d, sync2_q, sync2_d, deb_q, deb_d;
    logic [NUM_SW-1:0]   cap_q, cap_d, mask_q, mask_d, w1c;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [7:0]          pwm_q, pwm_d;
    logic                irq_q, irq_d, tick;
    logic [31:0]         rdata_q, rdata_d;
    logic                unused_wd;

    assign unused_wd    = ^avs_writedata[31:8];
    assign avs_readdata = rdata_q;
    assign irq          = irq_q;
    assign led_out      = led_q;

    // Next-state for bus registers, switch debounce, edge capture, irq and PWM
    always_comb begin
        sync1_d = sw_in;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        for (int i = 0; i < NUM_SW; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) deb_d[i] = sync2_q[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        w1c     = (avs_write && avs_address == 4'd9) ? avs_writedata[NUM_SW-1:0] : '0;
        cap_d   = (cap_q & ~w1c) | (deb_d ^ deb_q);
        mask_d  = (avs_write && avs_address == 4'd10) ? avs_writedata[NUM_SW-1:0] : mask_q;
        irq_d   = |(cap_q & mask_q);
        tick    = presc_q == PRE_MAX;
        presc_d = tick ? '0 : presc_q + 1'b1;
        pwm_d   = tick ? pwm_q + 8'd1 : pwm_q;
        for (int i = 0; i < NUM_LEDS; i++) begin
            shadow_d[i] = (avs_write && avs_address == 4'(i)) ? avs_writedata[7:0] : shadow_q[i];
            active_d[i] = (tick && pwm_q == 8'hff) ? shadow_q[i] : active_q[i];
            led_d[i]    = pwm_q < active_q[i];
        end
        rdata_d = '0;
        if (avs_read) begin
            for (int i = 0; i < NUM_LEDS; i++)
                if (avs_address == 4'(i)) rdata_d = {24'd0, shadow_q[i]};
            if (avs_address == 4'd8)  rdata_d = 32'(deb_q);
            if (avs_address == 4'd9)  rdata_d = 32'(cap_q);
            if (avs_address == 4'd10) rdata_d = 32'(mask_q);
        end
    end

    // State registers, all cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '{default: '0};
            active_q <= '{default: '0};
            cnt_q    <= '{default: '0};
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            cap_q    <= '0;
            mask_q   <= '0;
            irq_q    <= 1'b0;
            presc_q  <= '0;
            pwm_q    <= '0;
            led_q    <= '0;
            rdata_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            deb_q    <= deb_d;
            cap_q    <= cap_d;
            mask_q   <= mask_d;
            irq_q    <= irq_d;
            presc_q  <= presc_d;
            pwm_q    <= pwm_d;
            led_q    <= led_d;
            rdata_q  <= rdata_d;
        end
    end
endmodule

// File: tb/tb_led_sw_avalon_ctrl.sv
// tb_led_sw_avalon_ctrl: directed and random checks of led_sw_avalon_ctrl against a behavioural model
module tb_led_sw_avalon_ctrl;
    localparam int D = 4;
    localparam int P = 1;

    logic        clk = 1'b0;
    logic        reset, avs_read, avs_write, irq;
    logic [3:0]  avs_address, sw_in, sw_cur;
    logic [31:0] avs_writedata, avs_readdata;
    logic [7:0]  led_out;

    led_sw_avalon_ctrl #(.NUM_LEDS(8), .NUM_SW(4), .DEBOUNCE_CYCLES(D), .PWM_PRESCALE(P)) dut (
        .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .irq(irq), .sw_in(sw_in), .led_out(led_out)
    );

    always #5 clk = ~clk;

    int          errs = 0, checks = 0, k = 0, run [4], ones;
    logic [7:0]  m_sh [8], m_act [8], m_led;
    logic [3:0]  m_s1, m_s2, m_deb, m_cap, m_mask;
    logic        m_irq;
    logic [31:0] m_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_val(input logic [3:0] a);
        if (a < 8) return {24'd0, m_sh[a[2:0]]};
        if (a == 8) return {28'd0, m_deb};
        if (a == 9) return {28'd0, m_cap};
        if (a == 10) return {28'd0, m_mask};
        return 32'd0;
    endfunction

    // One clock: drive inputs, advance the model by the register-map rules, compare outputs
    task automatic step(input logic r, input logic rd, input logic wr, input logic [3:0] a,
                        input logic [31:0] wd, input logic [3:0] sw);
        logic [3:0] ndeb, w1c;
        int pwm;
        reset = r; avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = wd; sw_in = sw;
        @(posedge clk);
        if (r) begin
            k = 0; m_sh = '{default: 0}; m_act = '{default: 0}; run = '{default: 0};
            m_s1 = 0; m_s2 = 0; m_deb = 0; m_cap = 0; m_mask = 0; m_irq = 0; m_led = 0; m_rd = 0;
        end else begin
            m_rd = rd ? reg_val(a) : 32'd0;
            pwm = (k / P) % 256;
            for (int i = 0; i < 8; i++) m_led[i] = pwm < int'(m_act[i]);
            if (k % P == P - 1 && pwm == 255) m_act = m_sh;
            k++;
            m_irq = |(m_cap & m_mask);
            ndeb = m_deb;
            for (int j = 0; j < 4; j++) begin
                run[j] = (m_s2[j] != m_deb[j]) ? run[j] + 1 : 0;
                if (run[j] == D) begin
                    ndeb[j] = m_s2[j];
                    run[j] = 0;
                end
            end
            w1c = (wr && a == 9) ? wd[3:0] : 4'd0;
            m_cap = (m_cap & ~w1c) | (ndeb ^ m_deb);
            m_deb = ndeb;
            if (wr && a == 10) m_mask = wd[3:0];
            if (wr && a < 8) m_sh[a[2:0]] = wd[7:0];
            m_s2 = m_s1;
            m_s1 = sw;
        end
        #1;
        check("led_out", {24'd0, led_out}, {24'd0, m_led});
        check("irq", {31'd0, irq}, {31'd0, m_irq});
        check("readdata", avs_readdata, m_rd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, sw_cur);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        step(0, 0, 1, a, d, sw_cur);
    endtask

    task automatic rd_exp(input string tag, input logic [3:0] a, input logic [31:0] exp);
        step(0, 1, 0, a, 0, sw_cur);
        check(tag, avs_readdata, exp);
    endtask

    initial begin
        sw_cur = 0;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int a = 0; a <= 10; a++) rd_exp("reset_reg", 4'(a), 0);
        check("reset_led", {24'd0, led_out}, 0);
        check("reset_irq", {31'd0, irq}, 0);

        wr(0, 64);
        rd_exp("duty0_rd", 0, 64);
        check("led0_before_wrap", {31'd0, led_out[0]}, 0);
        idle(300);
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            idle(1);
            ones += int'(led_out[0]);
        end
        check("led0_ones_per_frame", 32'(ones), 64);

        sw_cur = 4'b0010;
        idle(6);
        rd_exp("sw_state_rise", 8, 2);
        rd_exp("edge_cap_rise", 9, 2);
        check("irq_masked", {31'd0, irq}, 0);

        wr(10, 2);
        idle(1);
        check("irq_unmasked", {31'd0, irq}, 1);
        wr(9, 0);
        idle(1);
        check("irq_w0_keeps", {31'd0, irq}, 1);
        rd_exp("edge_cap_w0", 9, 2);
        wr(9, 2);
        idle(1);
        rd_exp("edge_cap_w1c", 9, 0);
        check("irq_cleared", {31'd0, irq}, 0);

        sw_cur[0] = 1'b1;
        idle(3);
        sw_cur[0] = 1'b0;
        idle(8);
        rd_exp("glitch_sw_state", 8, 2);
        rd_exp("glitch_edge_cap", 9, 0);

        sw_cur[2] = 1'b1;
        idle(5);
        wr(9, 4);
        rd_exp("set_beats_w1c", 9, 4);
        rd_exp("sw_state_two", 8, 6);

        wr(3, 200);
        idle(37);
        step(1, 0, 0, 0, 0, sw_cur);
        check("midframe_reset_led", {24'd0, led_out}, 0);
        rd_exp("midframe_reset_duty", 3, 0);
        rd_exp("midframe_reset_duty0", 0, 0);

        for (int c = 0; c < 4000; c++) begin
            logic [1:0] op;
            for (int j = 0; j < 4; j++)
                if ($urandom_range(0, 11) == 0) sw_cur[j] = ~sw_cur[j];
            op = 2'($urandom_range(0, 3));
            step($urandom_range(0, 1499) == 0, op[0], op[1], 4'($urandom_range(0, 15)), $urandom, sw_cur);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
